// File: rtl/uart_rx_deframer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer_if
// Receive-side bus between the UART deframer and the RX FIFO write port.
//   o_rx_done     : one-clock strobe, o_rx_data holds a freshly received word
//   o_rx_data     : last correctly received word (NDATA_BITS wide)
//   o_frame_error : one-clock strobe, stop bit was sampled low
// Modports: master = deframer (drives), slave = FIFO / consumer (observes).
// ---------------------------------------------------------------------------
interface uart_rx_deframer_if #(
  parameter int NDATA_BITS = 8
);
  logic                  o_rx_done;
  logic [NDATA_BITS-1:0] o_rx_data;
  logic                  o_frame_error;

  modport master (
    output o_rx_done,
    output o_rx_data,
    output o_frame_error
  );

  modport slave (
    input o_rx_done,
    input o_rx_data,
    input o_frame_error
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// Oversampling UART receiver (16 ticks per bit, LSB first, start/data/stop).
// A good frame produces a one-clock o_rx_done with the word on o_rx_data; a
// frame whose stop bit is low produces a one-clock o_frame_error instead and
// leaves o_rx_data untouched.
// Ports:
//   i_clock  : system clock
//   i_reset  : synchronous, active-high reset
//   i_tick   : one-clock oversampling strobe from the shared baud generator
//   i_rx     : asynchronous serial line, idle high
//   rx_bus   : master side of uart_rx_deframer_if (done / data / frame error)
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int NDATA_BITS = 8,
  parameter int SB_TICK    = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_tick,
  input  logic                   i_rx,
  uart_rx_deframer_if.master     rx_bus
);

  // Tick counter must reach both 15 (data bits) and SB_TICK-1 (stop bit).
  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = $clog2(NDATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state_r, state_nx_s;
  logic [S_W-1:0]        s_r, s_nx_s;
  logic [N_W-1:0]        n_r, n_nx_s;
  logic [NDATA_BITS-1:0] b_r, b_nx_s;
  logic                  done_r, done_nx_s;
  logic                  ferr_r, ferr_nx_s;
  logic [NDATA_BITS-1:0] data_r, data_nx_s;
  logic                  rx_meta_r, rx_sync_r;
  logic                  rx_s;

  assign rx_s = rx_sync_r;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r <= IDLE;
      s_r     <= {S_W{1'b0}};
      n_r     <= {N_W{1'b0}};
      b_r     <= {NDATA_BITS{1'b0}};
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
      data_r  <= {NDATA_BITS{1'b0}};
    end else begin
      state_r <= state_nx_s;
      s_r     <= s_nx_s;
      n_r     <= n_nx_s;
      b_r     <= b_nx_s;
      done_r  <= done_nx_s;
      ferr_r  <= ferr_nx_s;
      data_r  <= data_nx_s;
    end
  end

  // Next-state and output decode; only IDLE may leave without a tick.
  always_comb begin
    state_nx_s = state_r;
    s_nx_s     = s_r;
    n_nx_s     = n_r;
    b_nx_s     = b_r;
    done_nx_s  = 1'b0;
    ferr_nx_s  = 1'b0;
    data_nx_s  = data_r;

    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nx_s = START;
          s_nx_s     = {S_W{1'b0}};
        end else begin
          state_nx_s = IDLE;
        end
      end

      START: begin
        if (i_tick) begin
          if (s_r == S_W'(7)) begin
            // Mid start bit: a high line here means the edge was a glitch.
            if (!rx_s) begin
              state_nx_s = DATA;
              s_nx_s     = {S_W{1'b0}};
              n_nx_s     = {N_W{1'b0}};
            end else begin
              state_nx_s = IDLE;
            end
          end else begin
            s_nx_s = s_r + S_W'(1);
          end
        end else begin
          s_nx_s = s_r;
        end
      end

      DATA: begin
        if (i_tick) begin
          if (s_r == S_W'(15)) begin
            s_nx_s = {S_W{1'b0}};
            // Shift in from the top so the first bit ends up in bit 0.
            b_nx_s = {rx_s, b_r[NDATA_BITS-1:1]};
            if (n_r == N_W'(NDATA_BITS - 1)) begin
              state_nx_s = STOP;
            end else begin
              n_nx_s = n_r + N_W'(1);
            end
          end else begin
            s_nx_s = s_r + S_W'(1);
          end
        end else begin
          s_nx_s = s_r;
        end
      end

      STOP: begin
        if (i_tick) begin
          if (s_r == S_W'(SB_TICK - 1)) begin
            state_nx_s = IDLE;
            if (rx_s) begin
              done_nx_s = 1'b1;
              data_nx_s = b_r;
            end else begin
              ferr_nx_s = 1'b1;
            end
          end else begin
            s_nx_s = s_r + S_W'(1);
          end
        end else begin
          s_nx_s = s_r;
        end
      end

      default: begin
        state_nx_s = IDLE;
        s_nx_s     = {S_W{1'b0}};
        n_nx_s     = {N_W{1'b0}};
      end
    endcase
  end

  assign rx_bus.o_rx_done     = done_r;
  assign rx_bus.o_rx_data     = data_r;
  assign rx_bus.o_frame_error = ferr_r;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
// Directed bench for uart_rx_deframer. Two instances share clock, reset and
// tick: dut_a uses one stop-bit time (SB_TICK=16), dut_b two (SB_TICK=32).
// Ticks arrive every 4th clock, so one bit time is 64 clocks.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_tick  = 1'b0;
  logic       rx_a;
  logic       rx_b;

  uart_rx_deframer_if #(.NDATA_BITS(8)) bus_a ();
  uart_rx_deframer_if #(.NDATA_BITS(8)) bus_b ();

  uart_rx_deframer #(.NDATA_BITS(8), .SB_TICK(16)) dut_a (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_tick  (i_tick),
    .i_rx    (rx_a),
    .rx_bus  (bus_a.master)
  );

  uart_rx_deframer #(.NDATA_BITS(8), .SB_TICK(32)) dut_b (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_tick  (i_tick),
    .i_rx    (rx_b),
    .rx_bus  (bus_b.master)
  );

  always #5 i_clock = ~i_clock;

  // Tick strobe: changes on the falling edge, high on every 4th clock.
  initial begin
    logic [1:0] div;
    div = 2'd0;
    forever begin
      @(negedge i_clock);
      div    = div + 2'd1;
      i_tick = (div == 2'd0);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int         tick_cnt   = 0;
  logic       last_tick  = 1'b0;
  int         done_a     = 0;
  int         ferr_a     = 0;
  int         both_a     = 0;
  logic [7:0] data_a     = 8'h00;
  int         dtick_a    = 0;
  int         dtick_prev = 0;
  int         done_b     = 0;
  int         ferr_b     = 0;
  logic [7:0] data_b     = 8'h00;
  int         dtick_b    = 0;
  int         start_tick = 0;

  // Tick bookkeeping as the DUTs see it on the rising edge.
  always @(posedge i_clock) begin
    last_tick <= i_tick;
    if (i_tick) tick_cnt <= tick_cnt + 1;
  end

  // Pulse monitor: counts clocks each strobe is high, away from the edge.
  always @(negedge i_clock) begin
    if (bus_a.o_rx_done === 1'b1) begin
      done_a     <= done_a + 1;
      data_a     <= bus_a.o_rx_data;
      dtick_prev <= dtick_a;
      dtick_a    <= tick_cnt;
    end
    if (bus_a.o_frame_error === 1'b1) ferr_a <= ferr_a + 1;
    if (bus_a.o_rx_done === 1'b1 && bus_a.o_frame_error === 1'b1) both_a <= both_a + 1;
    if (bus_b.o_rx_done === 1'b1) begin
      done_b  <= done_b + 1;
      data_b  <= bus_b.o_rx_data;
      dtick_b <= tick_cnt;
    end
    if (bus_b.o_frame_error === 1'b1) ferr_b <= ferr_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit on_b, input logic v);
    if (on_b) rx_b = v;
    else      rx_a = v;
  endtask

  task automatic wait_bit();
    repeat (64) @(negedge i_clock);
  endtask

  // Move to the falling edge right after a tick so DUT and bench tick counts line up.
  task automatic align();
    while (!last_tick) @(negedge i_clock);
  endtask

  // stop_kind: 0 = low stop bit, 1 = one stop bit, 2 = two stop bits.
  // rst_bit: data bit index during which a one-clock reset is pulsed (-1 = none).
  task automatic send_frame(input logic [7:0] d, input int stop_kind,
                            input int rst_bit, input bit on_b);
    start_tick = tick_cnt;
    set_line(on_b, 1'b0);
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      set_line(on_b, d[i]);
      if (i == rst_bit) begin
        repeat (32) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        check("rst_mid_done",  {31'd0, bus_a.o_rx_done},     32'd0);
        check("rst_mid_ferr",  {31'd0, bus_a.o_frame_error}, 32'd0);
        check("rst_mid_data",  {24'd0, bus_a.o_rx_data},     32'd0);
        repeat (31) @(negedge i_clock);
      end else begin
        wait_bit();
      end
    end
    if (stop_kind == 0) begin
      // Low stop bit covers the stop sample, then the line recovers before
      // the restarted start-bit check so no phantom frame follows.
      set_line(on_b, 1'b0);
      repeat (40) @(negedge i_clock);
      set_line(on_b, 1'b1);
      repeat (24) @(negedge i_clock);
    end else begin
      set_line(on_b, 1'b1);
      repeat (stop_kind) wait_bit();
    end
  endtask

  initial begin
    i_reset = 1'b1;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    check("reset_done",   {31'd0, bus_a.o_rx_done},     32'd0);
    check("reset_ferr",   {31'd0, bus_a.o_frame_error}, 32'd0);
    check("reset_data",   {24'd0, bus_a.o_rx_data},     32'd0);
    check("reset_data_b", {24'd0, bus_b.o_rx_data},     32'd0);
    repeat (8) @(negedge i_clock);

    // Good frame 0x55.
    align();
    send_frame(8'h55, 1, -1, 1'b0);
    check("good_done_cnt", done_a, 1);
    check("good_data",     {24'd0, data_a}, 32'h55);
    check("good_ferr_cnt", ferr_a, 0);
    check("good_latency",  dtick_a - start_tick, 152);

    // Start-bit glitch: 3 ticks low, then idle.
    align();
    rx_a = 1'b0;
    repeat (12) @(negedge i_clock);
    rx_a = 1'b1;
    repeat (128) @(negedge i_clock);
    check("glitch_done_cnt", done_a, 1);
    check("glitch_ferr_cnt", ferr_a, 0);
    align();
    send_frame(8'hA3, 1, -1, 1'b0);
    check("after_glitch_done", done_a, 2);
    check("after_glitch_data", {24'd0, data_a}, 32'hA3);

    // Bad stop bit.
    align();
    send_frame(8'h3C, 0, -1, 1'b0);
    check("ferr_cnt",      ferr_a, 1);
    check("ferr_done_cnt", done_a, 2);
    check("ferr_data_kept", {24'd0, bus_a.o_rx_data}, 32'hA3);

    // Back-to-back frames with no idle gap.
    align();
    send_frame(8'hA3, 1, -1, 1'b0);
    check("b2b_first_data", {24'd0, data_a}, 32'hA3);
    send_frame(8'h0F, 1, -1, 1'b0);
    check("b2b_done_cnt",   done_a, 4);
    check("b2b_second_data", {24'd0, data_a}, 32'h0F);
    check("b2b_spacing",    dtick_a - dtick_prev, 160);

    // Reset during data bit 4 of 0xFF, then a clean 0x81.
    align();
    send_frame(8'hFF, 1, 4, 1'b0);
    check("rst_no_done", done_a, 4);
    check("rst_no_ferr", ferr_a, 1);
    align();
    send_frame(8'h81, 1, -1, 1'b0);
    check("post_rst_done", done_a, 5);
    check("post_rst_data", {24'd0, bus_a.o_rx_data}, 32'h81);

    // Two stop-bit build: 0x7E with a 2-bit stop.
    check("sb32_idle_done", done_b, 0);
    align();
    send_frame(8'h7E, 2, -1, 1'b1);
    check("sb32_done_cnt", done_b, 1);
    check("sb32_data",     {24'd0, data_b}, 32'h7E);
    check("sb32_ferr_cnt", ferr_b, 0);
    // Last data sample falls 136 ticks after the start edge.
    check("sb32_stop_ticks", dtick_b - start_tick - 136, 32);

    check("never_both", both_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
